// File: rtl/kypd_emu_if.sv
// Keypad emulator bus: scanner-facing col/row lines plus the key-mask command handshake.
// The master is the scanner/commander side; the slave is the emulator.
interface kypd_emu_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        cmd_valid;
  logic [15:0] cmd_mask;
  logic        cmd_ready;
  logic        busy;
  logic        done;
  logic [15:0] pressed;

  modport master (
    output col, cmd_valid, cmd_mask,
    input  row, cmd_ready, busy, done, pressed
  );

  modport slave (
    input  col, cmd_valid, cmd_mask,
    output row, cmd_ready, busy, done, pressed
  );
endinterface

// File: rtl/kypd_emu.sv
// Pmod KYPD responder: drives active-low rows from active-low column strobes as a
// 4x4 keypad would, holding a commanded key mask for HOLD_CYCLES then releasing for GAP_CYCLES.
module kypd_emu #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter bit          SYNC_EN     = 1'b0
) (
  input logic       clk,
  input logic       rst,
  kypd_emu_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  // Key value at nibble index (row*4 + col).
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       held_q, held_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        sync2_q, sync2_d;

  logic [3:0]        colx;
  logic [3:0]        row_o;
  logic              cmd_ready;
  logic              accept;

  // Ready is gated by rst so a command presented during reset is never taken.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign colx      = SYNC_EN ? sync2_q : bus.col;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          held_d  = bus.cmd_mask;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          held_d  = '0;
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    sync1_d = bus.col;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // A row is pulled low when any strobed column crosses a held key on that row.
  always_comb begin
    logic [3:0] key;
    row_o = '1;
    key   = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        key = KEY_MAP[4*(r*4+c) +: 4];
        if (held_q[key] && !colx[c]) begin
          row_o[r] = 1'b0;
        end
      end
    end
  end

  assign bus.row       = row_o;
  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pressed   = held_q;

endmodule

// File: tb/tb_kypd_emu.sv
// Self-checking bench for kypd_emu: combinational and synchronized instances with HOLD=8, GAP=4.
module tb_kypd_emu;

  localparam int unsigned HOLD = 8;
  localparam int unsigned GAP  = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;

  kypd_emu_if b0 ();
  kypd_emu_if b1 ();

  kypd_emu #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .SYNC_EN(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  kypd_emu #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .SYNC_EN(1'b1)) u_dut_sync (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (!b0.cmd_ready && n < 40) begin
      tick();
      n++;
    end
    n_total++;
    if (b0.cmd_ready !== 1'b1) $display("FAIL wait_idle: cmd_ready=%b required 1 within 40 cycles", b0.cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    b0.col       = 4'b1110;
    b0.cmd_valid = 1'b1;
    b0.cmd_mask  = 16'h0001;
    b1.col       = 4'hF;
    b1.cmd_valid = 1'b0;
    b1.cmd_mask  = 16'h0000;
    repeat (3) begin
      tick();
      n_total++;
      if (b0.row !== 4'hF) $display("FAIL reset_row: got %h required %h", b0.row, 4'hF);
      else n_pass++;
      n_total++;
      if (b0.cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %b required 0", b0.cmd_ready);
      else n_pass++;
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (b0.cmd_ready !== 1'b1) $display("FAIL reset_ready_high: got %b required 1", b0.cmd_ready);
    else n_pass++;
    n_total++;
    if (b0.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", b0.busy);
    else n_pass++;
    n_total++;
    if (b0.pressed !== 16'h0000) $display("FAIL reset_pressed: got %h required 0000", b0.pressed);
    else n_pass++;
    n_total++;
    if (b0.done !== 1'b0) $display("FAIL reset_done: got %b required 0", b0.done);
    else n_pass++;
    tick();
    b0.cmd_valid = 1'b0;
    n_total++;
    if (b0.pressed !== 16'h0001) $display("FAIL reset_accept: pressed got %h required 0001", b0.pressed);
    else n_pass++;
    n_total++;
    if (b0.busy !== 1'b1) $display("FAIL reset_accept_busy: got %b required 1", b0.busy);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_single_key;
    b0.cmd_mask  = 16'h0020;
    b0.col       = 4'b1101;
    b0.cmd_valid = 1'b1;
    tick();
    b0.cmd_valid = 1'b0;
    b0.cmd_mask  = 16'hFFFF;
    for (int i = 0; i < int'(HOLD); i++) begin
      n_total++;
      if (b0.pressed !== 16'h0020) $display("FAIL single_pressed[%0d]: got %h required 0020", i, b0.pressed);
      else n_pass++;
      n_total++;
      if (b0.cmd_ready !== 1'b0) $display("FAIL single_ready_hold[%0d]: got %b required 0", i, b0.cmd_ready);
      else n_pass++;
      b0.col = 4'b1101;
      #1;
      n_total++;
      if (b0.row !== 4'b1101) $display("FAIL single_row_hit[%0d]: got %b required 1101", i, b0.row);
      else n_pass++;
      b0.col = 4'b1110;
      #1;
      n_total++;
      if (b0.row !== 4'hF) $display("FAIL single_row_miss[%0d]: got %b required 1111", i, b0.row);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < int'(GAP); i++) begin
      b0.col = 4'b1101;
      #1;
      n_total++;
      if (b0.pressed !== 16'h0000) $display("FAIL gap_pressed[%0d]: got %h required 0000", i, b0.pressed);
      else n_pass++;
      n_total++;
      if (b0.row !== 4'hF) $display("FAIL gap_row[%0d]: got %b required 1111", i, b0.row);
      else n_pass++;
      n_total++;
      if ({b0.cmd_ready, b0.done} !== 2'b00) $display("FAIL gap_ready_done[%0d]: got %b required 00", i, {b0.cmd_ready, b0.done});
      else n_pass++;
      tick();
    end
    n_total++;
    if ({b0.done, b0.cmd_ready, b0.busy} !== 3'b110) $display("FAIL single_done: done/ready/busy got %b required 110", {b0.done, b0.cmd_ready, b0.busy});
    else n_pass++;
    tick();
    n_total++;
    if (b0.done !== 1'b0) $display("FAIL single_done_pulse: got %b required 0", b0.done);
    else n_pass++;
  endtask

  task automatic test_multi_key;
    logic [3:0] cols [4];
    logic [3:0] rows [4];
    cols = '{4'b1110, 4'b1101, 4'b1011, 4'b1100};
    rows = '{4'b1100, 4'b0111, 4'b1111, 4'b0100};
    b0.cmd_mask  = 16'h8012;
    b0.cmd_valid = 1'b1;
    tick();
    b0.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b0.col = cols[i];
      #1;
      n_total++;
      if (b0.row !== rows[i]) $display("FAIL multi_row[col=%b]: got %b required %b", cols[i], b0.row, rows[i]);
      else n_pass++;
    end
    b0.col = 4'hF;
    wait_idle();
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q [$];
    int          acc_q [$];
    logic [15:0] exp_mask;
    int          n_acc;
    bit          saw_zero;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0400);
    n_acc        = 0;
    saw_zero     = 1'b0;
    b0.cmd_mask  = 16'h0001;
    b0.cmd_valid = 1'b1;
    for (int i = 0; i < 60 && n_acc < 2; i++) begin
      if (b0.cmd_valid && b0.cmd_ready) begin
        acc_q.push_back(cyc);
        n_acc++;
        tick();
        exp_mask = exp_q.pop_front();
        n_total++;
        if (b0.pressed !== exp_mask) $display("FAIL b2b_pressed[%0d]: got %h required %h", n_acc, b0.pressed, exp_mask);
        else n_pass++;
        if (n_acc == 1) b0.cmd_mask = 16'h0400;
        else b0.cmd_valid = 1'b0;
      end else begin
        if (n_acc == 1 && b0.pressed === 16'h0000) saw_zero = 1'b1;
        tick();
      end
    end
    b0.cmd_valid = 1'b0;
    n_total++;
    if (n_acc != 2) $display("FAIL b2b_accepts: got %0d required 2", n_acc);
    else n_pass++;
    n_total++;
    if (n_acc == 2 && (acc_q[1] - acc_q[0]) != int'(HOLD + GAP + 1))
      $display("FAIL b2b_spacing: got %0d required %0d", acc_q[1] - acc_q[0], HOLD + GAP + 1);
    else if (n_acc == 2) n_pass++;
    else $display("FAIL b2b_spacing: got no second accept required %0d", HOLD + GAP + 1);
    n_total++;
    if (saw_zero !== 1'b1) $display("FAIL b2b_gap_zero: got %b required 1", saw_zero);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_mid_hold;
    bit done_seen;
    b0.cmd_mask  = 16'hFFFF;
    b0.col       = 4'h0;
    b0.cmd_valid = 1'b1;
    tick();
    b0.cmd_valid = 1'b0;
    tick();
    tick();
    n_total++;
    if (b0.row !== 4'h0) $display("FAIL midhold_row_before: got %b required 0000", b0.row);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_total++;
    if (b0.row !== 4'hF) $display("FAIL midhold_row_after: got %b required 1111", b0.row);
    else n_pass++;
    n_total++;
    if (b0.cmd_ready !== 1'b0) $display("FAIL midhold_ready_in_rst: got %b required 0", b0.cmd_ready);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({b0.cmd_ready, b0.busy, b0.pressed} !== {1'b1, 1'b0, 16'h0000})
      $display("FAIL midhold_idle: ready/busy/pressed got %b/%b/%h required 1/0/0000", b0.cmd_ready, b0.busy, b0.pressed);
    else n_pass++;
    done_seen = 1'b0;
    repeat (20) begin
      tick();
      if (b0.done === 1'b1) done_seen = 1'b1;
    end
    n_total++;
    if (done_seen !== 1'b0) $display("FAIL midhold_no_done: got %b required 0", done_seen);
    else n_pass++;
    b0.col = 4'hF;
  endtask

  task automatic test_sync;
    b1.col       = 4'hF;
    b1.cmd_mask  = 16'h0200;
    b1.cmd_valid = 1'b1;
    tick();
    b1.cmd_valid = 1'b0;
    n_total++;
    if (b1.pressed !== 16'h0200) $display("FAIL sync_pressed: got %h required 0200", b1.pressed);
    else n_pass++;
    b1.col = 4'b1011;
    #1;
    n_total++;
    if (b1.row !== 4'hF) $display("FAIL sync_row_n: got %b required 1111", b1.row);
    else n_pass++;
    tick();
    n_total++;
    if (b1.row !== 4'hF) $display("FAIL sync_row_n1: got %b required 1111", b1.row);
    else n_pass++;
    tick();
    n_total++;
    if (b1.row !== 4'b1011) $display("FAIL sync_row_n2: got %b required 1011", b1.row);
    else n_pass++;
    b1.col = 4'hF;
    tick();
    n_total++;
    if (b1.row !== 4'b1011) $display("FAIL sync_release_n1: got %b required 1011", b1.row);
    else n_pass++;
    tick();
    n_total++;
    if (b1.row !== 4'hF) $display("FAIL sync_release_n2: got %b required 1111", b1.row);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_key();
    test_multi_key();
    test_back_to_back();
    test_reset_mid_hold();
    test_sync();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
